// File: rtl/rs2_fwd_ctrl_if.sv
// Bundle of ID-stage request fields and EX-stage operand-B select results for rs2_fwd_ctrl.
// RS2_FWD_STATS_EN adds the stall_cnt/fwd_cnt statistics outputs.
interface rs2_fwd_ctrl_if #(
    parameter int unsigned REGW = 5,
    parameter int unsigned SELW = 3
);
    logic            id_valid;
    logic [REGW-1:0] id_rs2;
    logic            id_uses_rs2;
    logic [1:0]      id_bsrc;
    logic [REGW-1:0] id_rd;
    logic            id_regwrite;
    logic            id_is_load;
    logic            ex_flush;
    logic            stall;
    logic            ex_valid;
    logic [SELW-1:0] rs2muxsel;
`ifdef RS2_FWD_STATS_EN
    logic [31:0]     stall_cnt;
    logic [31:0]     fwd_cnt;
`endif

    modport master (
        output id_valid, id_rs2, id_uses_rs2, id_bsrc, id_rd, id_regwrite, id_is_load, ex_flush,
`ifdef RS2_FWD_STATS_EN
        input  stall_cnt, fwd_cnt,
`endif
        input  stall, ex_valid, rs2muxsel
    );

    modport slave (
        input  id_valid, id_rs2, id_uses_rs2, id_bsrc, id_rd, id_regwrite, id_is_load, ex_flush,
`ifdef RS2_FWD_STATS_EN
        output stall_cnt, fwd_cnt,
`endif
        output stall, ex_valid, rs2muxsel
    );
endinterface

// File: rtl/rs2_fwd_ctrl.sv
// Operand-B select and hazard-stall control for the EX-stage ALU: tracks EX/MEM destination tags,
// registers rs2muxsel for EX and stalls ID when no forward path exists. RS2_FWD_STATS_EN adds counters.
module rs2_fwd_ctrl #(
    parameter int unsigned REGW = 5,
    parameter int unsigned SELW = 3
) (
    input logic           clk,
    input logic           rst,
    rs2_fwd_ctrl_if.slave bus
);

    localparam logic [SELW-1:0] SEL_RS2VAL = SELW'(0);
    localparam logic [SELW-1:0] SEL_ALUOUT = SELW'(1);
    localparam logic [SELW-1:0] SEL_LSJAL  = SELW'(2);
    localparam logic [SELW-1:0] SEL_AUILUI = SELW'(3);
    localparam logic [SELW-1:0] SEL_LS32   = SELW'(4);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LDUSE,
        ST_WBWAIT
    } state_e;

    state_e          state_q, state_d;

    logic            ex_v_q, ex_v_d;
    logic [REGW-1:0] ex_rd_q, ex_rd_d;
    logic            ex_wr_q, ex_wr_d;
    logic            ex_ld_q, ex_ld_d;
    logic            mem_v_q;
    logic [REGW-1:0] mem_rd_q;
    logic            mem_wr_q;
    logic [SELW-1:0] sel_q, sel_d;

    logic            rs2_fwdable;
    logic            match_ex;
    logic            match_mem;
    logic            stall;
    logic            issue;

    always_comb begin
        rs2_fwdable = bus.id_uses_rs2 && (bus.id_bsrc == 2'b00) && (bus.id_rs2 != '0);
        match_ex    = rs2_fwdable && ex_v_q && ex_wr_q && (ex_rd_q == bus.id_rs2);
        match_mem   = rs2_fwdable && mem_v_q && mem_wr_q && (mem_rd_q == bus.id_rs2);
        // A matching EX producer is younger and shadows MEM: only a load there can stall.
        stall       = bus.id_valid && (match_ex ? ex_ld_q : match_mem);
        issue       = bus.id_valid && !stall && !bus.ex_flush;
    end

    always_comb begin
        ex_v_d  = issue;
        ex_rd_d = issue ? bus.id_rd : '0;
        ex_wr_d = issue && bus.id_regwrite;
        ex_ld_d = issue && bus.id_is_load;
        sel_d   = SEL_RS2VAL;
        if (issue) begin
            unique case (bus.id_bsrc)
                2'b01:   sel_d = SEL_LSJAL;
                2'b10:   sel_d = SEL_AUILUI;
                2'b11:   sel_d = SEL_LS32;
                default: sel_d = (match_ex && !ex_ld_q) ? SEL_ALUOUT : SEL_RS2VAL;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.ex_flush) begin
            state_d = ST_RUN;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (bus.id_valid && match_ex && ex_ld_q) begin
                        state_d = ST_LDUSE;
                    end else if (stall) begin
                        state_d = ST_WBWAIT;
                    end
                end
                ST_LDUSE:  state_d = stall ? ST_WBWAIT : ST_RUN;
                ST_WBWAIT: state_d = ST_RUN;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            ex_v_q   <= 1'b0;
            ex_rd_q  <= '0;
            ex_wr_q  <= 1'b0;
            ex_ld_q  <= 1'b0;
            mem_v_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_wr_q <= 1'b0;
            sel_q    <= SEL_RS2VAL;
        end else begin
            state_q  <= state_d;
            ex_v_q   <= ex_v_d;
            ex_rd_q  <= ex_rd_d;
            ex_wr_q  <= ex_wr_d;
            ex_ld_q  <= ex_ld_d;
            mem_v_q  <= ex_v_q;
            mem_rd_q <= ex_rd_q;
            mem_wr_q <= ex_wr_q;
            sel_q    <= sel_d;
        end
    end

    assign bus.stall     = stall;
    assign bus.ex_valid  = ex_v_q;
    assign bus.rs2muxsel = sel_q;

`ifdef RS2_FWD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (issue && (sel_d == SEL_ALUOUT)) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_rs2_fwd_ctrl.sv
// Scoreboard bench for rs2_fwd_ctrl: directed hazard scenarios followed by random traffic,
// checked against an in-flight-producer reference model.
module tb_rs2_fwd_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rs2_fwd_ctrl_if #(.REGW(5), .SELW(3)) bus ();

    rs2_fwd_ctrl #(.REGW(5), .SELW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          v;
        int unsigned rd;
        bit          wr;
        bit          ld;
    } prod_t;

    typedef struct {
        bit          v;
        int unsigned sel;
    } exexp_t;

    // Youngest instruction first; at most the two slots that can still hazard against ID.
    prod_t       inflight[$];
    exexp_t      q_ex[$];
    bit          q_st[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned m_stall_cycles = 0;
    int unsigned m_fwd_issues   = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void model(input bit v, input int unsigned rs2, input bit uses,
                                  input int unsigned bsrc, input bit flush,
                                  output bit st, output bit iss, output int unsigned sel);
        st  = 1'b0;
        sel = 0;
        if (v && uses && bsrc == 0 && rs2 != 0) begin
            for (int i = 0; i < inflight.size(); i++) begin
                if (inflight[i].v && inflight[i].wr && inflight[i].rd == rs2) begin
                    // Only a non-load producer exactly one instruction ahead can forward.
                    if (i == 0 && !inflight[i].ld) sel = 1;
                    else st = 1'b1;
                    break;
                end
            end
        end
        iss = v && !st && !flush;
        if (!iss) sel = 0;
        else if (bsrc != 0) sel = bsrc + 1;
    endfunction

    task automatic drive_idle();
        bus.id_valid    = 1'b0;
        bus.id_rs2      = '0;
        bus.id_uses_rs2 = 1'b0;
        bus.id_bsrc     = '0;
        bus.id_rd       = '0;
        bus.id_regwrite = 1'b0;
        bus.id_is_load  = 1'b0;
        bus.ex_flush    = 1'b0;
    endtask

    task automatic step(input bit v, input int unsigned rs2, input bit uses, input int unsigned bsrc,
                        input int unsigned rd, input bit wr, input bit ld, input bit flush,
                        output bit st);
        bit          iss;
        int unsigned sel;
        prod_t       p;
        exexp_t      e;
        @(negedge clk);
        bus.id_valid    = v;
        bus.id_rs2      = 5'(rs2);
        bus.id_uses_rs2 = uses;
        bus.id_bsrc     = 2'(bsrc);
        bus.id_rd       = 5'(rd);
        bus.id_regwrite = wr;
        bus.id_is_load  = ld;
        bus.ex_flush    = flush;
        #1;
        model(v, rs2, uses, bsrc, flush, st, iss, sel);
        q_st.push_back(st);
        e.v   = iss;
        e.sel = sel;
        q_ex.push_back(e);
        if (st) m_stall_cycles++;
        if (iss && sel == 1) m_fwd_issues++;
        p.v  = iss;
        p.rd = iss ? rd : 0;
        p.wr = iss && wr;
        p.ld = iss && ld;
        inflight.push_front(p);
        if (inflight.size() > 2) void'(inflight.pop_back());
    endtask

    task automatic idle(input int unsigned n);
        bit st;
        for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, st);
    endtask

    // Present one instruction and hold it in ID while it stalls.
    task automatic issue_instr(input int unsigned rs2, input bit uses, input int unsigned bsrc,
                               input int unsigned rd, input bit wr, input bit ld);
        bit st;
        int unsigned n = 0;
        do begin
            step(1, rs2, uses, bsrc, rd, wr, ld, 0, st);
            n++;
        end while (st && n < 5);
    endtask

    task automatic do_reset_midcycle();
        #2;
        rst = 1'b1;
        #1;
        check("rst_stall", bus.stall, 0);
        check("rst_ex_valid", bus.ex_valid, 0);
        check("rst_rs2muxsel", bus.rs2muxsel, 0);
        drive_idle();
        inflight.delete();
        q_ex.delete();
        q_st.delete();
        m_stall_cycles = 0;
        m_fwd_issues   = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : mon_ex
        exexp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && q_ex.size() > 0) begin
                e = q_ex.pop_front();
                check("ex_valid", bus.ex_valid, e.v);
                check("rs2muxsel", bus.rs2muxsel, e.sel);
            end
        end
    end

    initial begin : mon_stall
        forever begin
            @(negedge clk);
            #2;
            if (!rst && q_st.size() > 0) check("stall", bus.stall, q_st.pop_front());
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit          st;
        bit          prev_st;
        bit          prev_flush;
        bit          v, uses, wr, ld, flush;
        int unsigned rs2, bsrc, rd;

        rst = 1'b1;
        drive_idle();
        #1;
        check("reset_stall", bus.stall, 0);
        check("reset_ex_valid", bus.ex_valid, 0);
        check("reset_rs2muxsel", bus.rs2muxsel, 0);
        @(negedge clk);
        rst = 1'b0;

        // EX-to-EX forward: add x5; sub uses x5
        issue_instr(0, 0, 0, 5, 1, 0);
        issue_instr(5, 1, 0, 9, 1, 0);
        idle(2);

        // Load-use: lw x7; add uses x7
        issue_instr(0, 0, 0, 7, 1, 1);
        issue_instr(7, 1, 0, 8, 1, 0);
        idle(2);

        // MEM-slot dependence, then the same pattern targeting x0
        issue_instr(0, 0, 0, 3, 1, 0);
        idle(1);
        issue_instr(3, 1, 0, 4, 1, 0);
        idle(2);
        issue_instr(0, 0, 0, 0, 1, 0);
        idle(1);
        issue_instr(0, 1, 0, 4, 1, 0);
        idle(2);

        // Address/immediate sources override any dependence on EX
        issue_instr(0, 0, 0, 6, 1, 0);
        issue_instr(6, 1, 2, 10, 1, 0);
        issue_instr(10, 1, 1, 11, 1, 0);
        issue_instr(11, 1, 3, 12, 1, 1);
        issue_instr(12, 1, 1, 13, 0, 0);
        idle(2);

        // Flush while the load-use stall is in its second cycle
        issue_instr(0, 0, 0, 7, 1, 1);
        step(1, 7, 1, 0, 8, 1, 0, 0, st);
        step(1, 7, 1, 0, 8, 1, 0, 1, st);
        idle(3);

        // Reset asserted in the middle of a load-use stall
        issue_instr(0, 0, 0, 7, 1, 1);
        step(1, 7, 1, 0, 8, 1, 0, 0, st);
        do_reset_midcycle();
        issue_instr(7, 1, 0, 8, 1, 0);
        idle(2);

        // Random traffic on a small register set to provoke frequent hazards
        prev_st    = 1'b0;
        prev_flush = 1'b0;
        v = 0; uses = 0; wr = 0; ld = 0; rs2 = 0; bsrc = 0; rd = 0;
        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) begin
                do_reset_midcycle();
                prev_st = 1'b0;
            end
            if (!prev_st || prev_flush) begin
                v    = ($urandom_range(0, 7) != 0);
                rs2  = $urandom_range(0, 3);
                uses = ($urandom_range(0, 3) != 0);
                bsrc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                rd   = $urandom_range(0, 3);
                wr   = ($urandom_range(0, 3) != 0);
                ld   = ($urandom_range(0, 2) == 0);
            end
            flush = ($urandom_range(0, 15) == 0);
            step(v, rs2, uses, bsrc, rd, wr, ld, flush, st);
            prev_st    = st;
            prev_flush = flush;
        end
        idle(3);

`ifdef RS2_FWD_STATS_EN
        @(negedge clk);
        #3;
        check("stall_cnt", bus.stall_cnt, m_stall_cycles);
        check("fwd_cnt", bus.fwd_cnt, m_fwd_issues);
`endif

        @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
